// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one RV32M muldiv unit between NREQ requesters.
// Divide-by-zero and signed overflow are answered locally without starting the unit.
module muldiv_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*3-1:0]    req_op,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 md_start,
  output logic [2:0]           md_op,
  output logic [31:0]          md_a,
  output logic [31:0]          md_b,
  input  logic [31:0]          md_result,
  input  logic                 md_done,
  input  logic                 md_busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] FAST  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [2:0] OP_DIV = 3'd4;
  localparam logic [2:0] OP_REM = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] grant_idx;
  logic          grant_any;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   result_q, result_d;
  logic          err_q, err_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [2:0]    sel_op;
  logic [31:0]   sel_a, sel_b;
  logic          fast_sel;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_any && req_valid[PW'((32'(rr_ptr_q) + k) % NREQ)]) begin
        grant_any = 1'b1;
        grant_idx = PW'((32'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    sel_op = req_op[2:0];
    sel_a  = req_a[31:0];
    sel_b  = req_b[31:0];
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[32*i +: 32];
        sel_b  = req_b[32*i +: 32];
      end
    end
  end

  assign fast_sel = (sel_op[2] && (sel_b == 32'h0)) ||
                    (((sel_op == OP_DIV) || (sel_op == OP_REM)) &&
                     (sel_a == 32'h8000_0000) && (sel_b == 32'hFFFF_FFFF));

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    md_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d  = grant_idx;
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          rr_ptr_d = PW'((32'(grant_idx) + 32'd1) % NREQ);
          state_d  = fast_sel ? FAST : START;
        end
      end
      START: begin
        if (!md_busy) begin
          md_start = 1'b1;
          cnt_d    = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (md_done) begin
          result_d = md_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_d == CW'(TIMEOUT - 1)) begin
          result_d = 32'h0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      FAST: begin
        err_d = 1'b0;
        // op[1] separates REM/REMU from DIV/DIVU.
        if (b_q == 32'h0) begin
          result_d = op_q[1] ? a_q : 32'hFFFF_FFFF;
        end else begin
          result_d = op_q[1] ? 32'h0 : 32'h8000_0000;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  assign rsp_result = result_q;
  assign rsp_err    = err_q;
  assign md_op      = op_q;
  assign md_a       = a_q;
  assign md_b       = b_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Bench for muldiv_arbiter: directed table, corner sequences and random traffic
// against an arithmetic RV32M model that also drives a behavioural muldiv unit.
module tb_muldiv_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [31:0] md_result = 32'h0;
  logic        md_done   = 1'b0;
  logic        md_busy;

  muldiv_arbiter #(.NREQ(2), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_a       (md_a),
    .md_b       (md_b),
    .md_result  (md_result),
    .md_done    (md_done),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] q;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_fast(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    return (op >= 3'd4 && b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural muldiv unit: samples operands at start, answers after fake_lat cycles.
  int          fake_lat   = 3;
  logic        no_done    = 1'b0;
  logic        force_busy = 1'b0;
  logic        f_pend     = 1'b0;
  int          f_cnt      = 0;
  logic [31:0] f_res      = 32'h0;
  logic [2:0]  cap_op     = 3'h0;
  logic [31:0] cap_a      = 32'h0;
  logic [31:0] cap_b      = 32'h0;
  int          n_starts   = 0;
  int          stab_err   = 0;

  assign md_busy = f_pend | force_busy;

  always @(posedge clk) begin
    if (md_start) n_starts <= n_starts + 1;
    if (!rst_n) begin
      f_pend  <= 1'b0;
      md_done <= 1'b0;
    end else begin
      md_done <= 1'b0;
      if (f_pend) begin
        if (md_op !== cap_op || md_a !== cap_a || md_b !== cap_b) stab_err <= stab_err + 1;
        if (f_cnt == 1) begin
          md_done   <= 1'b1;
          md_result <= f_res;
          f_pend    <= 1'b0;
        end else begin
          f_cnt <= f_cnt - 1;
        end
      end
      if (md_start && !no_done) begin
        f_pend <= 1'b1;
        f_cnt  <= fake_lat;
        f_res  <= ref_md(md_op, md_a, md_b);
        cap_op <= md_op;
        cap_a  <= md_a;
        cap_b  <= md_b;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  st_op;
  logic [31:0] st_a, st_b;

  // One request on requester r; cycle 0 is the handshake cycle.
  task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int busy_n, input int hold,
                       output logic [31:0] res, output logic err, output int start_cyc,
                       output int rsp_cyc, output int nstart);
    int   n, c, base;
    logic got, done;
    res = 0; err = 0; start_cyc = -1; rsp_cyc = -1;
    base = n_starts;
    req_op[3*r +: 3] = op;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_valid[r] = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 100) begin
      #1;
      if (req_ready[r]) got = 1'b1;
      tick();
      n++;
    end
    req_valid[r] = 1'b0;
    if (!got) chk("grant_wait", 32'd0, 32'd1);
    c = 1;
    done = 1'b0;
    while (got && !done && c < 200) begin
      force_busy = (c <= busy_n);
      #1;
      if (md_start && start_cyc < 0) begin
        start_cyc = c;
        st_op = md_op;
        st_a  = md_a;
        st_b  = md_b;
      end
      if (rsp_valid != 2'b00) begin
        chk("rsp_onehot", {30'h0, rsp_valid}, 32'd1 << r);
        rsp_cyc = c;
        res  = rsp_result;
        err  = rsp_err;
        done = 1'b1;
      end else begin
        tick();
        c++;
      end
    end
    force_busy = 1'b0;
    if (got && !done) chk("rsp_wait", 32'd0, 32'd1);
    for (int h = 0; h < hold && done; h++) begin
      tick();
      #1;
      chk("hold_valid", {31'h0, rsp_valid[r]}, 32'd1);
      chk("hold_result", rsp_result, res);
      chk("hold_err", {31'h0, rsp_err}, {31'h0, err});
    end
    rsp_ready[r] = 1'b1;
    tick();
    rsp_ready[r] = 1'b0;
    #1;
    if (done) chk("rsp_drop", {30'h0, rsp_valid}, 32'd0);
    nstart = n_starts - base;
  endtask

  typedef struct {
    int          r;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        fast;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] res;
    logic        err;
    int          sc, rc, ns, grants, resps, outstanding, owner, cyc, stray;
    logic [2:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{0, 3'd0, 32'd7,         32'd6,         32'd42,        1'b0};
    vecs[1]  = '{1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[2]  = '{0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[3]  = '{1, 3'd5, 32'd123,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{0, 3'd7, 32'd123,       32'd0,         32'd123,       1'b1};
    vecs[5]  = '{1, 3'd4, 32'd123,       32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{0, 3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1};
    vecs[7]  = '{1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[9]  = '{1, 3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{0, 3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{1, 3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[12] = '{0, 3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{1, 3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0};

    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    repeat (3) tick();
    #1;
    chk("reset_req_ready", {30'h0, req_ready}, 32'd0);
    chk("reset_rsp_valid", {30'h0, rsp_valid}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("reset_md_start", {31'h0, md_start}, 32'd0);
    chk("reset_md_op", {29'h0, md_op}, 32'd0);
    chk("reset_md_a", md_a, 32'd0);
    chk("reset_md_b", md_b, 32'd0);
    rst_n = 1'b1;
    tick();

    // Contention: both requesters ask continuously, grants must alternate 0,1,0,1.
    fake_lat = 3;
    req_op = {3'd5, 3'd5};
    req_a  = {32'd100, 32'd100};
    req_b  = {32'd7, 32'd7};
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    grants = 0; resps = 0; outstanding = 0; owner = 0; cyc = 0;
    while (resps < 4 && cyc < 400) begin
      #1;
      if (req_ready != 2'b00) begin
        chk("grant_order", {30'h0, req_ready}, (grants % 2 == 0) ? 32'd1 : 32'd2);
        chk("grant_while_busy", outstanding, 32'd0);
        outstanding = 1;
        owner = grants % 2;
        grants++;
      end
      if (rsp_valid != 2'b00) begin
        chk("rr_rsp_owner", {30'h0, rsp_valid}, 32'd1 << owner);
        chk("rr_rsp_divu", rsp_result, 32'd14);
        outstanding = 0;
        resps++;
      end
      tick();
      cyc++;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    chk("rr_responses", resps, 32'd4);
    tick();

    for (int i = 0; i < 14; i++) begin
      fake_lat = $urandom_range(1, 6);
      issue(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, res, err, sc, rc, ns);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_err", i), {31'h0, err}, 32'd0);
      if (vecs[i].fast) begin
        chk($sformatf("vec%0d_no_start", i), ns, 32'd0);
        chk($sformatf("vec%0d_fast_lat", i), rc, 32'd2);
      end else begin
        chk($sformatf("vec%0d_starts", i), ns, 32'd1);
        chk($sformatf("vec%0d_start_cyc", i), sc, 32'd1);
        chk($sformatf("vec%0d_rsp_cyc", i), rc, sc + 2 + fake_lat);
        chk($sformatf("vec%0d_md_op", i), {29'h0, st_op}, {29'h0, vecs[i].op});
        chk($sformatf("vec%0d_md_a", i), st_a, vecs[i].a);
        chk($sformatf("vec%0d_md_b", i), st_b, vecs[i].b);
      end
    end

    // Unit busy for three cycles delays the start pulse.
    fake_lat = 2;
    issue(0, 3'd0, 32'd3, 32'd5, 3, 0, res, err, sc, rc, ns);
    chk("busy_result", res, 32'd15);
    chk("busy_start_cyc", sc, 32'd4);
    chk("busy_rsp_cyc", rc, sc + 2 + fake_lat);

    // Unit never answers: error response 64 cycles after start, held while not accepted.
    no_done = 1'b1;
    issue(1, 3'd0, 32'd9, 32'd9, 0, 5, res, err, sc, rc, ns);
    no_done = 1'b0;
    chk("timeout_err", {31'h0, err}, 32'd1);
    chk("timeout_result", res, 32'd0);
    chk("timeout_delay", rc - sc, 32'd64);
    chk("timeout_starts", ns, 32'd1);

    // Reset while waiting on the unit aborts the operation.
    fake_lat = 20;
    req_op[2:0] = 3'd0; req_a[31:0] = 32'd11; req_b[31:0] = 32'd11;
    req_valid[0] = 1'b1;
    #1;
    chk("abort_grant", {30'h0, req_ready}, 32'd1);
    tick();
    req_valid[0] = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_rsp_valid", {30'h0, rsp_valid}, 32'd0);
    chk("abort_md_start", {31'h0, md_start}, 32'd0);
    chk("abort_md_a", md_a, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("abort_rr_ptr", {30'h0, req_ready}, 32'd1);
    req_valid = 2'b00;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      #1;
      if (rsp_valid != 2'b00) stray++;
    end
    chk("abort_no_rsp", stray, 32'd0);
    fake_lat = 2;
    issue(1, 3'd0, 32'd9, 32'd9, 0, 0, res, err, sc, rc, ns);
    chk("after_reset_result", res, 32'd81);
    chk("after_reset_start", sc, 32'd1);

    for (int i = 0; i < 40; i++) begin
      int r, busy_n;
      r  = $urandom_range(0, 1);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      fake_lat = $urandom_range(1, 10);
      busy_n = $urandom_range(0, 2);
      issue(r, op, a, b, busy_n, 0, res, err, sc, rc, ns);
      chk($sformatf("rand%0d_result op%0d %h %h", i, op, a, b), res, ref_md(op, a, b));
      chk($sformatf("rand%0d_err", i), {31'h0, err}, 32'd0);
      if (is_fast(op, a, b)) begin
        chk($sformatf("rand%0d_no_start", i), ns, 32'd0);
        chk($sformatf("rand%0d_fast_lat", i), rc, 32'd2);
      end else begin
        chk($sformatf("rand%0d_starts", i), ns, 32'd1);
        chk($sformatf("rand%0d_start_cyc", i), sc, 32'(busy_n + 1));
        chk($sformatf("rand%0d_rsp_cyc", i), rc, sc + 2 + fake_lat);
      end
    end

    chk("operand_stable", stab_err, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
